uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
//   Uses round-robin arbitration with message locking: a grant is held until
//   the byte flagged last has been sent, or until the owner goes idle for too long.
//   Sits between the firmware/debug byte sources and uart_tx.
//   Sequences uart_tx through tx_start / tx_busy.
// PARAMETERS
//   NUM_REQ       4      number of requesters, 2..16
//   LOCK_TIMEOUT  1024   idle cycles in HOLD before a locked grant is revoked; 0 = never, max 65535
// PORTS
//   clk             in   1          clock
//   resetn          in   1          synchronous, active-low reset
//   req_valid       in   NUM_REQ    requester i has a byte; held until req_ready[i]
//   req_data        in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//   req_last        in   NUM_REQ    byte ends the message; releases the grant
//   req_ready       out  NUM_REQ    one-cycle accept pulse, at most one bit set
//   uart_tx_start   out  1          start pulse to uart_tx
//   uart_tx_byte    out  8          byte to uart_tx, stable from LOAD+1 until the next LOAD
//   uart_tx_busy    in   1          uart_tx busy flag
//   grant_id        out  clog2(NUM_REQ), min 1   current owner index
//   grant_active    out  1          high from LOAD entry until release
//   timeout_pulse   out  1          one cycle when a locked grant is revoked by timeout
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, rr pointer = NUM_REQ-1 so requester 0 wins first.
//   Reset mid-operation: outputs are 0 the cycle after reset is sampled; no byte is accepted.
//   All outputs are registered or decoded from registered state only; no input->output comb path.
//   FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, HOLD.
//   IDLE:
//     - Arbitrates only when |req_valid && !uart_tx_busy.
//     - Winner = first i with req_valid[i], scanning from rr+1 mod NUM_REQ upward with wrap.
//     - Registers grant_id; next state LOAD.
//   LOAD:
//     - req_ready[grant_id]=1 for exactly this cycle.
//     - Captures req_data/req_last of the owner into uart_tx_byte / last_q.
//     - Next state START.
//   START: uart_tx_start=1 for exactly one cycle; next state WAIT_BUSY.
//   WAIT_BUSY: stays until uart_tx_busy=1, then WAIT_DONE.
//   WAIT_DONE: stays until uart_tx_busy=0, then:
//     - last_q=1: release. rr <= grant_id, grant_active <= 0, next state IDLE.
//     - last_q=0: next state HOLD. Timeout counter cleared.
//   HOLD: grant stays locked; other requesters are ignored.
//     - req_valid[grant_id]=1: next state LOAD, counter cleared.
//     - Otherwise counter increments. When it reaches LOCK_TIMEOUT-1 (LOCK_TIMEOUT!=0):
//       timeout_pulse=1, release as above, next state IDLE.
//   Latency: req_valid seen in IDLE -> req_ready 1 cycle later -> uart_tx_start 2 cycles later.
//   Locked next byte: req_valid seen in HOLD -> uart_tx_start 2 cycles later.
//   Simultaneous requests: exactly one winner by rr order; losers keep valid asserted.
//   Winner valid cannot drop before ready (held-valid protocol); no recheck is needed in LOAD.
//   rr wraps NUM_REQ-1 -> 0. Timeout counter is 16 bits and never wraps.
//   Single-byte message (req_last=1 on the first byte): full release after that byte.
// TESTING
//   - Reset, then valid[0]=1 data=0x55 last=1 -> ready[0] at T+1, tx_start at T+2, tx_byte=0x55, grant released after busy falls.
//   - All four requesters valid, last=1 -> grants go 0,1,2,3,0 and each ready pulses exactly once.
//   - Req1 sends 3-byte message 0xA1,0xA2,0xA3(last) while req2 is valid -> req2 waits until 0xA3 completes.
//   - Req0 sends a non-last byte then idles, LOCK_TIMEOUT=8 -> timeout_pulse 8 cycles into HOLD, then req3 granted.
//   - resetn low during WAIT_DONE -> all outputs 0 the next cycle; the FSM restarts cleanly with a fresh request.
//   - Random valid/last traffic with a uart_tx model -> bytes per requester in order, no interleaving within a message.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte streams.
// An owner keeps the grant until its last byte is sent or it idles past LOCK_TIMEOUT.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [8*NUM_REQ-1:0]                   req_data,
  input  logic [NUM_REQ-1:0]                     req_last,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   uart_tx_start,
  output logic [7:0]                             uart_tx_byte,
  input  logic                                   uart_tx_busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                   grant_active,
  output logic                                   timeout_pulse
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST = (LOCK_TIMEOUT == 0) ? '0 : CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    HOLD      = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic                active_q, active_d;
  logic                last_q, last_d;
  logic [7:0]          byte_q, byte_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                start_q, start_d;
  logic                timeout_q, timeout_d;

  logic                win_found;
  logic [GW-1:0]       win_idx;
  logic [GW-1:0]       cand;

  // Round-robin pick: first valid requester after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    cand      = rr_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(rr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    active_d  = active_q;
    last_d    = last_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found && !uart_tx_busy) begin
          grant_d  = win_idx;
          active_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        byte_d  = req_data[{grant_q, 3'b000} +: 8];
        last_d  = req_last[grant_q];
        state_d = START;
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            rr_d     = grant_q;
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Locked: only the owner can continue; the counter saturates instead of wrapping.
        if (req_valid[grant_q]) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else if ((LOCK_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          timeout_d = 1'b1;
          rr_d      = grant_q;
          active_d  = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    ready_d = (state_d == LOAD) ? (NUM_REQ'(1) << grant_d) : '0;
    start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rr_q      <= GW'(NUM_REQ - 1);
      grant_q   <= '0;
      active_q  <= 1'b0;
      last_q    <= 1'b0;
      byte_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      active_q  <= active_d;
      last_q    <= last_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_ready     = ready_q;
  assign uart_tx_start = start_q;
  assign uart_tx_byte  = byte_q;
  assign grant_id      = grant_q;
  assign grant_active  = active_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomised checks of uart_tx_arbiter against a simple uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned LOCK_TIMEOUT = 8;
  localparam int          BUSY_LEN     = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_byte;
  logic                 uart_tx_busy;
  logic [1:0]           grant_id;
  logic                 grant_active;
  logic                 timeout_pulse;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte), .uart_tx_busy(uart_tx_busy),
    .grant_id(grant_id), .grant_active(grant_active), .timeout_pulse(timeout_pulse)
  );

  int         total = 0;
  int         bad   = 0;
  logic [8:0] rq[NUM_REQ][$];
  logic [8:0] exp_q[NUM_REQ][$];
  int         log_g[$];
  logic [7:0] log_b[$];
  int         rdy_cnt[NUM_REQ];
  int         busy_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [8:0] hd;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() != 0) begin
        hd = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = hd[7:0];
        req_last[i]        = hd[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] b);
    rq[i].push_back({last, b});
    drive_reqs();
  endtask

  // One clock: sample outputs mid-cycle, advance requesters and the uart model after the edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] rdy;
    logic               st;
    rdy = req_ready;
    st  = uart_tx_start;
    if (st) begin
      log_g.push_back(int'(grant_id));
      log_b.push_back(uart_tx_byte);
    end
    if (rdy != '0) check_eq("ready_onehot", 32'($countones(rdy)), 1);
    for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] += int'(rdy[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (rdy[i] && resetn && rq[i].size() != 0) void'(rq[i].pop_front());
    if (!resetn)           busy_cnt = 0;
    else if (st)           busy_cnt = BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt--;
    uart_tx_busy = (busy_cnt != 0);
    drive_reqs();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      exp_q[i].delete();
      rdy_cnt[i] = 0;
    end
    log_g.delete();
    log_b.delete();
    drive_reqs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    clear_all();
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    logic pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      pend = grant_active || uart_tx_busy;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) pend = 1'b1;
      if (pend) begin
        cycle();
        n++;
      end
    end
    check_eq("wait_idle_in_budget", 32'(n < budget), 1);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (!uart_tx_start && n < budget) begin
      cycle();
      n++;
    end
    check_eq("start_seen", 32'(uart_tx_start), 1);
  endtask

  task automatic check_log(input string tag, input int idx, input int g, input logic [7:0] b);
    check_eq({tag, "_gid"},  32'(log_g[idx]), 32'(g));
    check_eq({tag, "_byte"}, 32'(log_b[idx]), 32'(b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    int open;
    int owner;
    int g;
    logic [8:0] e;
    logic [7:0] b;

    resetn = 1'b0;
    uart_tx_busy = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset values
    check_eq("rst_ready",   32'(req_ready), 0);
    check_eq("rst_start",   32'(uart_tx_start), 0);
    check_eq("rst_byte",    32'(uart_tx_byte), 0);
    check_eq("rst_gid",     32'(grant_id), 0);
    check_eq("rst_active",  32'(grant_active), 0);
    check_eq("rst_timeout", 32'(timeout_pulse), 0);

    // Single-byte message from requester 0: ready at T+1, start at T+2
    push(0, 1'b1, 8'h55);
    cycle();
    check_eq("t1_ready",  32'(req_ready), 32'h1);
    check_eq("t1_active", 32'(grant_active), 1);
    check_eq("t1_gid",    32'(grant_id), 0);
    check_eq("t1_nostart", 32'(uart_tx_start), 0);
    cycle();
    check_eq("t1_start",   32'(uart_tx_start), 1);
    check_eq("t1_byte",    32'(uart_tx_byte), 32'h55);
    check_eq("t1_ready_off", 32'(req_ready), 0);
    wait_idle(60);
    check_eq("t1_released", 32'(grant_active), 0);
    check_eq("t1_log_len", 32'(log_g.size()), 1);
    check_log("t1", 0, 0, 8'h55);

    // All four requesters: grants 0,1,2,3,0
    do_reset();
    push(0, 1'b1, 8'h10);
    push(1, 1'b1, 8'h11);
    push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13);
    push(0, 1'b1, 8'h14);
    wait_idle(200);
    check_eq("t2_log_len", 32'(log_g.size()), 5);
    for (int i = 0; i < 5; i++) check_log("t2", i, i % 4, 8'(8'h10 + i));
    check_eq("t2_rdy0", 32'(rdy_cnt[0]), 2);
    check_eq("t2_rdy1", 32'(rdy_cnt[1]), 1);
    check_eq("t2_rdy2", 32'(rdy_cnt[2]), 1);
    check_eq("t2_rdy3", 32'(rdy_cnt[3]), 1);

    // Locked 3-byte message from requester 1 with requester 2 waiting
    clear_all();
    push(1, 1'b0, 8'hA1);
    push(1, 1'b0, 8'hA2);
    push(1, 1'b1, 8'hA3);
    push(2, 1'b1, 8'hB0);
    wait_idle(200);
    check_eq("t3_log_len", 32'(log_g.size()), 4);
    check_log("t3_0", 0, 1, 8'hA1);
    check_log("t3_1", 1, 1, 8'hA2);
    check_log("t3_2", 2, 1, 8'hA3);
    check_log("t3_3", 3, 2, 8'hB0);

    // Owner idles in HOLD: timeout 14 cycles after start (8 into HOLD), then requester 3
    clear_all();
    push(0, 1'b0, 8'h77);
    wait_start(20);
    push(3, 1'b1, 8'h33);
    n = 0;
    while (!timeout_pulse && n < 40) begin
      cycle();
      n++;
    end
    check_eq("t4_to_latency", 32'(n), 14);
    check_eq("t4_to_released", 32'(grant_active), 0);
    cycle();
    check_eq("t4_to_one_cycle", 32'(timeout_pulse), 0);
    check_eq("t4_ready3", 32'(req_ready), 32'h8);
    check_eq("t4_gid3", 32'(grant_id), 3);
    wait_idle(100);
    check_eq("t4_log_len", 32'(log_g.size()), 2);
    check_log("t4_0", 0, 0, 8'h77);
    check_log("t4_1", 1, 3, 8'h33);

    // Reset during WAIT_DONE, then a fresh request
    clear_all();
    push(2, 1'b1, 8'hC2);
    wait_start(20);
    cycle();
    cycle();
    check_eq("t5_active_pre", 32'(grant_active), 1);
    resetn = 1'b0;
    cycle();
    check_eq("t5_ready",   32'(req_ready), 0);
    check_eq("t5_start",   32'(uart_tx_start), 0);
    check_eq("t5_byte",    32'(uart_tx_byte), 0);
    check_eq("t5_gid",     32'(grant_id), 0);
    check_eq("t5_active",  32'(grant_active), 0);
    check_eq("t5_timeout", 32'(timeout_pulse), 0);
    resetn = 1'b1;
    clear_all();
    push(1, 1'b1, 8'h5A);
    cycle();
    check_eq("t5_ready1", 32'(req_ready), 32'h2);
    check_eq("t5_gid1",   32'(grant_id), 1);
    cycle();
    check_eq("t5_start1", 32'(uart_tx_start), 1);
    check_eq("t5_byte1",  32'(uart_tx_byte), 32'h5A);
    wait_idle(60);
    check_eq("t5_log_len", 32'(log_g.size()), 1);
    check_log("t5", 0, 1, 8'h5A);

    // Random multi-byte messages on all requesters
    clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int m = 0; m < 3; m++) begin
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          e = {(k == len - 1), b};
          rq[i].push_back(e);
          exp_q[i].push_back(e);
        end
      end
    end
    drive_reqs();
    wait_idle(2000);
    open = 0;
    owner = 0;
    for (int j = 0; j < log_g.size(); j++) begin
      g = log_g[j];
      if (open != 0 && g != owner) check_eq("rand_interleave", 32'(g), 32'(owner));
      if (exp_q[g].size() != 0) begin
        e = exp_q[g].pop_front();
        check_eq("rand_byte", 32'(log_b[j]), 32'(e[7:0]));
        open  = e[8] ? 0 : 1;
        owner = g;
      end else begin
        check_eq("rand_extra", 32'(exp_q[g].size()), 1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) check_eq("rand_left", 32'(exp_q[i].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
